// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data RAM: one access per cycle, read data routed back to the issuing port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_memR,
  output logic              mem_memW,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [7:0]        conflict_cnt
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  port_e       last_gnt_q, last_gnt_d;
  port_e       rd_owner_q, rd_owner_d;
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  conflict_cnt_q, conflict_cnt_d;

  logic req0, req1, conflict, pick1, gnt0, gnt1, rd_issue;

  // Requests are masked in reset so every grant-derived output drops immediately.
  assign req0     = p0_req & rst_n;
  assign req1     = p1_req & rst_n;
  assign conflict = req0 & req1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pick1 = req1;
    if (conflict) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick1 = (last_gnt_q == PORT0);
`else
      pick1 = 1'b0;
`endif
    end
  end

  assign gnt0 = req0 & ~pick1;
  assign gnt1 = req1 & pick1;

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_memW = 1'b0;
    if (gnt0) begin
      mem_addr = p0_addr;
      mem_din  = p0_wdata;
      mem_memW = p0_we;
    end else if (gnt1) begin
      mem_addr = p1_addr;
      mem_din  = p1_wdata;
      mem_memW = p1_we;
    end
  end

  assign rd_issue = (gnt0 & ~p0_we) | (gnt1 & ~p1_we);

  always_comb begin
    rd_pend_d      = rd_issue;
    rd_owner_d     = rd_owner_q;
    last_gnt_d     = last_gnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (rd_issue) rd_owner_d = gnt1 ? PORT1 : PORT0;
    if (gnt0) last_gnt_d = PORT0;
    else if (gnt1) last_gnt_d = PORT1;
    if (conflict && (conflict_cnt_q != 8'hFF)) conflict_cnt_d = conflict_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q     <= PORT1;
      rd_owner_q     <= PORT0;
      rd_pend_q      <= 1'b0;
      conflict_cnt_q <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      last_gnt_q     <= last_gnt_d;
      rd_owner_q     <= rd_owner_d;
      rd_pend_q      <= rd_pend_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // The RAM only drives dout while memR is high, so memR marks the return cycle.
  assign mem_memR     = rd_pend_q;
  assign p0_gnt       = gnt0;
  assign p1_gnt       = gnt1;
  assign p0_rvalid    = rd_pend_q & (rd_owner_q == PORT0);
  assign p1_rvalid    = rd_pend_q & (rd_owner_q == PORT1);
  assign p0_rdata     = p0_rvalid ? mem_dout : '0;
  assign p1_rdata     = p1_rvalid ? mem_dout : '0;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, a per-cycle reference model check, and directed scenarios with literal expectations.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic [7:0] mem_addr, mem_din, mem_dout;
  logic       mem_memR, mem_memW;
  logic [7:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_memR(mem_memR), .mem_memW(mem_memW),
    .mem_din(mem_din), .mem_dout(mem_dout), .conflict_cnt(conflict_cnt)
  );

  // Behavioural 256x8 RAM: address registered every edge, dout gated by memR.
  logic [7:0] ram [256];
  logic [7:0] ram_addr_q = 8'd0;
  always @(posedge clk) begin
    if (mem_memW) ram[mem_addr] <= mem_din;
    ram_addr_q <= mem_addr;
  end
  assign mem_dout = mem_memR ? ram[ram_addr_q] : 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scoreboard memory plus the arbiter's architectural state.
  logic [7:0] sb_mem [256];
  int         m_last = 1, m_owner = 0, m_cnt = 0, g;
  bit         m_pend = 0;
  logic [7:0] m_addr = 8'd0;
  int         n_last, n_owner, n_cnt;
  bit         n_pend, n_w, r0, r1;
  logic [7:0] n_addr, n_wd, ea, ed, rdv;
  logic       ew;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_last = 1; m_pend = 0; m_owner = 0; m_cnt = 0;
      end
      r0 = rst_n && p0_req;
      r1 = rst_n && p1_req;
      if (r0 && r1) g = (RR && m_last == 0) ? 1 : 0;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
      else          g = -1;
      ea  = (g == 0) ? p0_addr  : (g == 1) ? p1_addr  : 8'd0;
      ed  = (g == 0) ? p0_wdata : (g == 1) ? p1_wdata : 8'd0;
      ew  = (g == 0) ? p0_we    : (g == 1) ? p1_we    : 1'b0;
      rdv = m_pend ? sb_mem[m_addr] : 8'd0;
      check("cyc p0_gnt",    32'(p0_gnt),    32'(g == 0));
      check("cyc p1_gnt",    32'(p1_gnt),    32'(g == 1));
      check("cyc mem_addr",  32'(mem_addr),  32'(ea));
      check("cyc mem_din",   32'(mem_din),   32'(ed));
      check("cyc mem_memW",  32'(mem_memW),  32'(ew));
      check("cyc mem_memR",  32'(mem_memR),  32'(m_pend));
      check("cyc p0_rvalid", 32'(p0_rvalid), 32'(m_pend && m_owner == 0));
      check("cyc p1_rvalid", 32'(p1_rvalid), 32'(m_pend && m_owner == 1));
      check("cyc p0_rdata",  32'(p0_rdata),  32'((m_pend && m_owner == 0) ? rdv : 8'd0));
      check("cyc p1_rdata",  32'(p1_rdata),  32'((m_pend && m_owner == 1) ? rdv : 8'd0));
      check("cyc conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
      n_pend  = (g >= 0) && !ew;
      n_owner = n_pend ? g : m_owner;
      n_addr  = ea;
      n_last  = (g >= 0) ? g : m_last;
      n_cnt   = (r0 && r1 && m_cnt < 255) ? m_cnt + 1 : m_cnt;
      n_w     = (g >= 0) && ew;
      n_wd    = ed;
      @(posedge clk);
      if (!rst_n) begin
        m_last = 1; m_pend = 0; m_owner = 0; m_cnt = 0;
      end else begin
        m_last = n_last; m_pend = n_pend; m_owner = n_owner;
        m_addr = n_addr; m_cnt = n_cnt;
        if (n_w) sb_mem[n_addr] = n_wd;
      end
    end
  end

  task automatic drive(input logic r0_i, input logic w0_i, input logic [7:0] a0_i, input logic [7:0] d0_i,
                       input logic r1_i, input logic w1_i, input logic [7:0] a1_i, input logic [7:0] d1_i);
    p0_req = r0_i; p0_we = w0_i; p0_addr = a0_i; p0_wdata = d0_i;
    p1_req = r1_i; p1_we = w1_i; p1_addr = a1_i; p1_wdata = d1_i;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 8'h00;
      sb_mem[i] = 8'h00;
    end
    ram[1] = 8'h11; sb_mem[1] = 8'h11;
    ram[2] = 8'h22; sb_mem[2] = 8'h22;

    // Reset with both masters requesting: everything must stay quiet.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 8'h10, 8'hAA, 1'b1, 1'b0, 8'h11, 8'h00);
    #3;
    check("rst p0_gnt", 32'(p0_gnt), 32'd0);
    check("rst p1_gnt", 32'(p1_gnt), 32'd0);
    check("rst mem_memW", 32'(mem_memW), 32'd0);
    check("rst mem_memR", 32'(mem_memR), 32'd0);
    check("rst rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
    step(); step();
    check("rst conflict_cnt", 32'(conflict_cnt), 32'd0);
    rst_n = 1'b1;
    idle();

    // Port 0 writes 0xA5 to 0x10, port 1 reads it back.
    step(); drive(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00); #2;
    check("wr p0_gnt", 32'(p0_gnt), 32'd1);
    check("wr mem_memW", 32'(mem_memW), 32'd1);
    check("wr mem_addr", 32'(mem_addr), 32'h10);
    check("wr mem_din", 32'(mem_din), 32'hA5);
    step(); drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00); #2;
    check("rd p1_gnt", 32'(p1_gnt), 32'd1);
    check("rd p1_rvalid early", 32'(p1_rvalid), 32'd0);
    step(); idle(); #2;
    check("rd p1_rvalid", 32'(p1_rvalid), 32'd1);
    check("rd p1_rdata", 32'(p1_rdata), 32'hA5);
    check("rd p0_rvalid", 32'(p0_rvalid), 32'd0);
    check("rd mem_memR", 32'(mem_memR), 32'd1);

    // Back-to-back port 0 reads with no bubble.
    step(); drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); #2;
    check("b2b gnt0", 32'(p0_gnt), 32'd1);
    step(); drive(1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); #2;
    check("b2b rvalid1", 32'(p0_rvalid), 32'd1);
    check("b2b rdata1", 32'(p0_rdata), 32'h11);
    check("b2b gnt1", 32'(p0_gnt), 32'd1);
    step(); idle(); #2;
    check("b2b rvalid2", 32'(p0_rvalid), 32'd1);
    check("b2b rdata2", 32'(p0_rdata), 32'h22);
    step(); #2;
    check("b2b rvalid end", 32'(p0_rvalid), 32'd0);

    // Read followed by a write to the same address: the return carries the old value.
    step(); drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step(); drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'h5A); #2;
    check("raw p0_rdata old", 32'(p0_rdata), 32'hA5);
    check("raw p1_gnt", 32'(p1_gnt), 32'd1);
    step(); drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    step(); idle(); #2;
    check("raw p1_rdata new", 32'(p1_rdata), 32'h5A);

    // Fresh reset, then four conflicting cycles.
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1'b1, 1'b1, 8'h20, 8'(8'h30 + i), 1'b1, 1'b1, 8'h21, 8'(8'h40 + i));
      #2;
      check("conf p1_gnt", 32'(p1_gnt), RR ? 32'(i % 2) : 32'd0);
      check("conf p0_gnt", 32'(p0_gnt), RR ? 32'((i + 1) % 2) : 32'd1);
    end
    step(); idle(); #2;
    check("conf cnt4", 32'(conflict_cnt), 32'd4);

    // Saturation of the conflict counter.
    for (int i = 0; i < 300; i++) begin
      step();
      drive(1'b1, 1'b1, 8'h30, 8'(i), 1'b1, 1'b1, 8'h31, 8'(i));
    end
    step(); idle(); #2;
    check("conf cnt sat", 32'(conflict_cnt), 32'd255);

    // Reset pulsed during the return cycle of a port 1 read.
    step(); drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00); #2;
    check("rstrd p1_gnt", 32'(p1_gnt), 32'd1);
    step(); idle();
    check("rstrd rvalid before", 32'(p1_rvalid), 32'd1);
    check("rstrd rdata before", 32'(p1_rdata), 32'h11);
    rst_n = 1'b0;
    #1;
    check("rstrd rvalid drop", 32'(p1_rvalid), 32'd0);
    check("rstrd memR drop", 32'(mem_memR), 32'd0);
    step(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      check("rstrd no rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
